// File: rtl/seq_deser_pkg.sv
// -----------------------------------------------------------------------------
// seq_deser_pkg
//
// Shared definitions for the serial-to-parallel receiver:
//   cnt_w()        width of the bit counter for a given word width
//   hold_state_e   occupancy of the output holding register
// -----------------------------------------------------------------------------
package seq_deser_pkg;

  // Bit counter width. Counts 0..width-1, so $clog2(width) bits suffice.
  // Usable in constant expressions (parameter / localparam sizing).
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

  // Holding register occupancy. FULL is exactly the word_valid condition.
  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } hold_state_e;

endpackage : seq_deser_pkg

// File: rtl/seq_bit_deserializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_deserializer_if
//
// Bundles the serial input and the parallel word handshake of the receiver.
//
//   bit_valid   source -> rx   bit_in is valid this cycle
//   bit_in      source -> rx   serial data bit
//   word_ready  sink   -> rx   consumer takes word when word_valid=1
//   word_valid  rx -> sink     word holds an unconsumed assembled word
//   word        rx -> sink     assembled word (registered)
//   bit_count   rx -> any      bits collected toward the current word
//   overrun     rx -> any      sticky: a completed word was dropped
//
// Modports:
//   master  the environment (bit source + word consumer)
//   slave   the deserializer itself
// -----------------------------------------------------------------------------
interface seq_bit_deserializer_if
  import seq_deser_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int CW = cnt_w(WIDTH);

  logic             bit_valid;
  logic             bit_in;
  logic             word_ready;
  logic             word_valid;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bit_count;
  logic             overrun;

  modport master (
    output bit_valid,
    output bit_in,
    output word_ready,
    input  word_valid,
    input  word,
    input  bit_count,
    input  overrun
  );

  modport slave (
    input  bit_valid,
    input  bit_in,
    input  word_ready,
    output word_valid,
    output word,
    output bit_count,
    output overrun
  );

endinterface : seq_bit_deserializer_if

// File: rtl/seq_deser_shift.sv
// -----------------------------------------------------------------------------
// seq_deser_shift
//
// Shift register plus bit counter. Every accepted bit is shifted in and
// counted; the bit that brings the count to WIDTH completes a word.
//
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bit_valid  accept bit_in this cycle
//   bit_in     serial data bit
//   assembled  shift register contents *including* this cycle's bit_in,
//              i.e. the complete word when done=1
//   done       this cycle's bit completes a word (combinational pulse)
//   bit_count  bits collected toward the current word (registered)
//
// LSB_FIRST=1 shifts right inserting at the MSB, so after WIDTH bits the
// first bit sits in bit 0. LSB_FIRST=0 shifts left inserting at the LSB, so
// the first bit ends up in bit WIDTH-1.
// -----------------------------------------------------------------------------
module seq_deser_shift
  import seq_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_valid,
  input  logic                    bit_in,
  output logic [WIDTH-1:0]        assembled,
  output logic                    done,
  output logic [cnt_w(WIDTH)-1:0] bit_count
);

  localparam int            CW   = cnt_w(WIDTH);
  // Terminal count at full counter width; for power-of-two WIDTH the wrap
  // comes from this compare rather than from counter overflow.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    count_q;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shreg_next = {bit_in, shreg_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign shreg_next = {shreg_q[WIDTH-2:0], bit_in};
    end
  endgenerate

  assign done      = bit_valid && (count_q == LAST);
  assign assembled = shreg_next;
  assign bit_count = count_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
    end else if (done) begin
      shreg_q <= shreg_next;
      count_q <= '0;
    end else if (bit_valid) begin
      shreg_q <= shreg_next;
      count_q <= count_q + CW'(1);
    end
  end

endmodule : seq_deser_shift

// File: rtl/seq_bit_deserializer.sv
// -----------------------------------------------------------------------------
// seq_bit_deserializer
//
// Serial-to-parallel receiver. One bit per cycle under bit_valid is
// assembled into a WIDTH-bit word which is then offered through a
// word_valid/word_ready handshake from a single holding register.
//
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (clears all state and outputs)
//   bus   seq_bit_deserializer_if.slave:
//           bit_valid, bit_in, word_ready  (in)
//           word_valid, word, bit_count, overrun (out)
//
// The holding register accepts a new word when it is empty or when the old
// word is being taken on the same edge. A word that completes while the
// register is full and not being read is dropped and sets the sticky
// overrun flag; the old word stays put.
// -----------------------------------------------------------------------------
module seq_bit_deserializer
  import seq_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  seq_bit_deserializer_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] assembled;
  logic             done;
  logic [CW-1:0]    bit_count;

  hold_state_e      hold_q;
  logic [WIDTH-1:0] word_q;
  logic             overrun_q;
  logic             hold_free;

  seq_deser_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bus.bit_valid),
    .bit_in    (bus.bit_in),
    .assembled (assembled),
    .done      (done),
    .bit_count (bit_count)
  );

  // Free if empty, or if the current word leaves on this edge.
  assign hold_free = (hold_q == FREE) || bus.word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= FREE;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else if (done) begin
      if (hold_free) begin
        word_q <= assembled;
        hold_q <= FULL;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if ((hold_q == FULL) && bus.word_ready) begin
      hold_q <= FREE;
    end
  end

  assign bus.word_valid = (hold_q == FULL);
  assign bus.word       = word_q;
  assign bus.bit_count  = bit_count;
  assign bus.overrun    = overrun_q;

endmodule : seq_bit_deserializer

// File: tb/tb_seq_bit_deserializer.sv
module tb_seq_bit_deserializer;
  import seq_deser_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_bit_deserializer_if #(.WIDTH(W)) if_l ();
  seq_bit_deserializer_if #(.WIDTH(W)) if_m ();

  seq_bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  seq_bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits received so far for the current word, and the
  // holding register as a transaction-level record.
  bit          mq[$];
  bit          m_valid;
  logic [W-1:0] m_word_l;
  logic [W-1:0] m_word_m;
  bit          m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic bv, input logic bi, input logic rdy);
    rst = r;
    if_l.bit_valid = bv; if_l.bit_in = bi; if_l.word_ready = rdy;
    if_m.bit_valid = bv; if_m.bit_in = bi; if_m.word_ready = rdy;
  endtask

  task automatic model_update(input logic r, input logic bv, input logic bi, input logic rdy);
    bit complete;
    logic [W-1:0] wl, wm;
    complete = 1'b0;
    wl = '0;
    wm = '0;
    if (r) begin
      mq.delete();
      m_valid  = 1'b0;
      m_word_l = '0;
      m_word_m = '0;
      m_ovr    = 1'b0;
    end else begin
      if (bv) begin
        mq.push_back(bi);
        if (mq.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wl = wl | (W'(mq[i]) << i);
            wm = wm | (W'(mq[i]) << (W - 1 - i));
          end
          mq.delete();
          complete = 1'b1;
        end
      end
      if (complete) begin
        if (!m_valid || rdy) begin
          m_word_l = wl;
          m_word_m = wm;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock: apply inputs, advance the model on the edge, compare #1 later.
  task automatic step(input logic r, input logic bv, input logic bi, input logic rdy);
    drive(r, bv, bi, rdy);
    @(posedge clk);
    model_update(r, bv, bi, rdy);
    #1;
    check("lsb.word_valid", 32'(if_l.word_valid), 32'(m_valid));
    check("lsb.word",       32'(if_l.word),       32'(m_word_l));
    check("lsb.bit_count",  32'(if_l.bit_count),  32'(mq.size()));
    check("lsb.overrun",    32'(if_l.overrun),    32'(m_ovr));
    check("msb.word_valid", 32'(if_m.word_valid), 32'(m_valid));
    check("msb.word",       32'(if_m.word),       32'(m_word_m));
    check("msb.bit_count",  32'(if_m.bit_count),  32'(mq.size()));
    check("msb.overrun",    32'(if_m.overrun),    32'(m_ovr));
  endtask

  // Send a word so that the LSB_FIRST=1 instance assembles v. gap idle
  // cycles follow each bit except the last; rdy_last applies to the last bit.
  task automatic send_word(input logic [W-1:0] v, input logic rdy_body,
                           input logic rdy_last, input int gap);
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, v[i], (i == W - 1) ? rdy_last : rdy_body);
      if (i != W - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy_body);
    end
  endtask

  typedef struct {
    logic         r, bv, bi, rdy;
    logic         ev;
    logic [W-1:0] ew_l, ew_m;
    int           ec;
    logic         eo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] pat;
    pat = 8'b0100_1101;   // stream 1,0,1,1,0,0,1,0 read from bit 0 upward

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Directed table: reset, the 8-bit stream with ready=1, one idle cycle.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[i+1] = '{1'b0, 1'b1, pat[i], 1'b1, (i == 7),
                    (i == 7) ? 8'h4D : 8'h00, (i == 7) ? 8'hB2 : 8'h00,
                    (i + 1) % 8, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 8'hB2, 0, 1'b0};

    for (int k = 0; k < 10; k++) begin
      step(vecs[k].r, vecs[k].bv, vecs[k].bi, vecs[k].rdy);
      check("tbl.lsb.valid", 32'(if_l.word_valid), 32'(vecs[k].ev));
      check("tbl.lsb.word",  32'(if_l.word),       32'(vecs[k].ew_l));
      check("tbl.msb.word",  32'(if_m.word),       32'(vecs[k].ew_m));
      check("tbl.count",     32'(if_l.bit_count),  32'(vecs[k].ec));
      check("tbl.overrun",   32'(if_l.overrun),    32'(vecs[k].eo));
    end

    // Gaps: each bit followed by two idle cycles.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b1, 1'b1, 2);
    check("gap.word",  32'(if_l.word),       32'h A5);
    check("gap.valid", 32'(if_l.word_valid), 32'd1);

    // Stalled consumer: second word is dropped, overrun sticks.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b0, 0);
    check("ovr.word",    32'(if_l.word),       32'h11);
    check("ovr.valid",   32'(if_l.word_valid), 32'd1);
    check("ovr.overrun", 32'(if_l.overrun),    32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr.drain.valid",   32'(if_l.word_valid), 32'd0);
    check("ovr.drain.overrun", 32'(if_l.overrun),    32'd1);

    // Back-to-back: ready rises exactly when the second word completes.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0, 0);
    send_word(8'h3C, 1'b0, 1'b1, 0);
    check("b2b.word",    32'(if_l.word),       32'h3C);
    check("b2b.valid",   32'(if_l.word_valid), 32'd1);
    check("b2b.overrun", 32'(if_l.overrun),    32'd0);

    // Reset after 5 bits discards the partial word.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst.valid",   32'(if_l.word_valid), 32'd0);
    check("rst.word",    32'(if_l.word),       32'd0);
    check("rst.count",   32'(if_l.bit_count),  32'd0);
    check("rst.overrun", 32'(if_l.overrun),    32'd0);
    send_word(8'hFF, 1'b1, 1'b1, 0);
    check("rst.after.lsb", 32'(if_l.word), 32'hFF);
    check("rst.after.msb", 32'(if_m.word), 32'hFF);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75),
           1'($urandom), ($urandom_range(0, 99) < 45));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_bit_deserializer
